bola_nave: RTL and testbench

Player projectile. Fires upward from the player ship on a button press and climbs one step per movement tick. It detects collision with a single enemy box and reports hits as a pulse plus a saturating counter. It sits beside the enemy-projectile logic in the game core and feeds the renderer (x/y) and the score/enemy-kill logic (acerto, n_acertos).

---
 rtl/bola_nave.sv | 192 +++++++++++++++++++
 tb/tb_bola_nave.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bola_nave.sv
// rtl/bola_nave.sv - player projectile: fire, climb per tick, enemy-box hit detection and hit counter
// Optional build macro AUTO_FIRE_EN: fire on the synchronized button level instead of its rising edge.
module bola_nave #(
    parameter int TICK_DIV       = 50000,
    parameter int STEP           = 2,
    parameter int NAVE_W         = 45,
    parameter int ENEMY_W        = 40,
    parameter int ENEMY_H        = 30,
    parameter int HIT_TICKS      = 60,
    parameter int COOLDOWN_TICKS = 200,
    parameter int OFFSCREEN      = 1000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic       disparo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] x_inimigo,
    input  logic [9:0] y_inimigo,
    input  logic       inimigo_vivo,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       ativa,
    output logic       explodindo,
    output logic       acerto,
    output logic [7:0] n_acertos
);

    localparam int         TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [9:0] OFF = 10'(OFFSCREEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLYING,
        S_HIT,
        S_COOLDOWN
    } state_t;

    state_t        state_q;
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          tick;
    logic          disp_meta_q;
    logic          disp_sync_q;
    logic          disp_prev_q;
    logic          fire_req;
    logic          pending_q;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic [7:0]    phase_q;
    logic          ativa_q;
    logic          explodindo_q;
    logic          acerto_q;
    logic [7:0]    n_acertos_q;
    logic          hit;

    // Tick generator freezes in place while paused.
    always_comb begin
        tick       = !pausa && (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick_cnt_q;
        if (!pausa) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            disp_meta_q <= 1'b0;
            disp_sync_q <= 1'b0;
            disp_prev_q <= 1'b0;
        end else begin
            disp_meta_q <= disparo;
            disp_sync_q <= disp_meta_q;
            disp_prev_q <= disp_sync_q;
        end
    end

`ifdef AUTO_FIRE_EN
    assign fire_req = disp_sync_q;
`else
    assign fire_req = disp_sync_q & ~disp_prev_q;
`endif

    // Box test widened to 11 bits so the far edges never wrap near 1023.
    always_comb begin
        hit = inimigo_vivo
            && ({1'b0, x_inimigo} <= {1'b0, x_q})
            && ({1'b0, x_q} <= {1'b0, x_inimigo} + 11'(ENEMY_W - 1))
            && ({1'b0, y_inimigo} <= {1'b0, y_q})
            && ({1'b0, y_q} <= {1'b0, y_inimigo} + 11'(ENEMY_H - 1));
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            pending_q    <= 1'b0;
            x_q          <= OFF;
            y_q          <= OFF;
            phase_q      <= 8'd0;
            ativa_q      <= 1'b0;
            explodindo_q <= 1'b0;
            acerto_q     <= 1'b0;
            n_acertos_q  <= 8'd0;
        end else if (reiniciarJogo) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            pending_q    <= 1'b0;
            x_q          <= OFF;
            y_q          <= OFF;
            phase_q      <= 8'd0;
            ativa_q      <= 1'b0;
            explodindo_q <= 1'b0;
            acerto_q     <= 1'b0;
            n_acertos_q  <= 8'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            acerto_q   <= 1'b0;
            if (state_q == S_IDLE && !pausa && fire_req) begin
                pending_q <= 1'b1;
            end
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        // Consuming the request overrides a same-cycle set above.
                        if (pending_q) begin
                            pending_q <= 1'b0;
                            if (y_nave != 10'd0) begin
                                x_q     <= x_nave + 10'(NAVE_W / 2);
                                y_q     <= y_nave - 10'd1;
                                state_q <= S_FLYING;
                                ativa_q <= 1'b1;
                            end
                        end
                    end
                    S_FLYING: begin
                        if (hit) begin
                            acerto_q     <= 1'b1;
                            if (n_acertos_q != 8'hFF) begin
                                n_acertos_q <= n_acertos_q + 8'd1;
                            end
                            state_q      <= S_HIT;
                            phase_q      <= 8'd0;
                            ativa_q      <= 1'b0;
                            explodindo_q <= 1'b1;
                        end else if (y_q < 10'(STEP)) begin
                            x_q     <= OFF;
                            y_q     <= OFF;
                            state_q <= S_COOLDOWN;
                            phase_q <= 8'd0;
                            ativa_q <= 1'b0;
                        end else begin
                            y_q <= y_q - 10'(STEP);
                        end
                    end
                    S_HIT: begin
                        if (phase_q == 8'(HIT_TICKS - 1)) begin
                            x_q          <= OFF;
                            y_q          <= OFF;
                            state_q      <= S_COOLDOWN;
                            phase_q      <= 8'd0;
                            explodindo_q <= 1'b0;
                        end else begin
                            phase_q <= phase_q + 8'd1;
                        end
                    end
                    S_COOLDOWN: begin
                        if (phase_q == 8'(COOLDOWN_TICKS - 1)) begin
                            state_q <= S_IDLE;
                            phase_q <= 8'd0;
                        end else begin
                            phase_q <= phase_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign ativa      = ativa_q;
    assign explodindo = explodindo_q;
    assign acerto     = acerto_q;
    assign n_acertos  = n_acertos_q;

endmodule

// File: tb/tb_bola_nave.sv
// tb/tb_bola_nave.sv - self-checking bench for bola_nave with a small tick divider
module tb_bola_nave;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       pausa = 1'b0;
    logic       reiniciarJogo = 1'b0;
    logic       disparo = 1'b0;
    logic [9:0] x_nave = 10'd100;
    logic [9:0] y_nave = 10'd400;
    logic [9:0] x_inimigo = 10'd300;
    logic [9:0] y_inimigo = 10'd50;
    logic       inimigo_vivo = 1'b1;
    logic [9:0] x;
    logic [9:0] y;
    logic       ativa;
    logic       explodindo;
    logic       acerto;
    logic [7:0] n_acertos;

    bola_nave #(
        .TICK_DIV(4),
        .STEP(2),
        .HIT_TICKS(3),
        .COOLDOWN_TICKS(5)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .pausa(pausa),
        .reiniciarJogo(reiniciarJogo),
        .disparo(disparo),
        .x_nave(x_nave),
        .y_nave(y_nave),
        .x_inimigo(x_inimigo),
        .y_inimigo(y_inimigo),
        .inimigo_vivo(inimigo_vivo),
        .x(x),
        .y(y),
        .ativa(ativa),
        .explodindo(explodindo),
        .acerto(acerto),
        .n_acertos(n_acertos)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int          compared = 0;
    int          mismatched = 0;
    int          acerto_cnt = 0;
    int          expl_cnt = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always @(negedge CLOCK_50) begin
        if (acerto === 1'b1) acerto_cnt++;
        if (explodindo === 1'b1) expl_cnt++;
    end

    task automatic expect_v(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic pulse_fire();
        disparo = 1'b1;
        step(3);
        disparo = 1'b0;
        step(3);
    endtask

    task automatic restart();
        reiniciarJogo = 1'b1;
        step(1);
        reiniciarJogo = 1'b0;
    endtask

    task automatic wait_ativa(input logic v, input int bound, output logic ok);
        int n = 0;
        while (ativa !== v && n < bound) begin step(1); n++; end
        ok = (ativa === v);
    endtask

    task automatic wait_y(input logic [9:0] v, input int bound, output logic ok);
        int n = 0;
        while (y !== v && n < bound) begin step(1); n++; end
        ok = (y === v);
    endtask

    task automatic wait_y_change(input int bound, output logic ok);
        logic [9:0] prev;
        int n = 0;
        prev = y;
        while (y === prev && n < bound) begin step(1); n++; end
        ok = (y !== prev);
    endtask

    task automatic wait_acerto(input int bound, output logic ok);
        int n = 0;
        while (acerto !== 1'b1 && n < bound) begin step(1); n++; end
        ok = (acerto === 1'b1);
    endtask

    initial begin
        logic        ok;
        int          a0;
        int          e0;
        int          ecnt;
        int          timeouts;
        logic [9:0]  fx;
        logic [9:0]  fy;

        // Reset state and quiet period
        step(3);
        reset = 1'b0;
        step(1);
        expect_v("reset_x", 1000);      check_v(x);
        expect_v("reset_y", 1000);      check_v(y);
        expect_v("reset_n", 0);         check_v(n_acertos);
        expect_v("reset_ativa", 0);     check_v(ativa);
        expect_v("reset_expl", 0);      check_v(explodindo);
        step(200);
        expect_v("quiet_acerto", 0);    check_v(acerto_cnt);

        // Ship on row 0 cannot fire and the request is discarded
        y_nave = 10'd0;
        pulse_fire();
        step(20);
        expect_v("y0_no_shot", 0);      check_v(ativa);
        y_nave = 10'd400;
        step(20);
        expect_v("y0_pending_cleared", 0); check_v(ativa);
        expect_v("y0_x", 1000);         check_v(x);

        // Miss: climb to the top edge
        x_nave = 10'd100; y_nave = 10'd400;
        x_inimigo = 10'd300; y_inimigo = 10'd50; inimigo_vivo = 1'b1;
        expect_v("spawn_ok", 1);
        expect_v("spawn_x", 122);
        expect_v("spawn_y", 399);
        pulse_fire();
        wait_ativa(1'b1, 30, ok);
        check_v(ok); check_v(x); check_v(y);
        for (int v = 397; v >= 1; v -= 2) begin
            expect_v("climb_y", v);
            wait_y_change(8, ok);
            check_v(y);
        end
        expect_v("top_y", 1000);
        wait_y_change(8, ok);
        check_v(y);
        expect_v("top_x", 1000);        check_v(x);
        expect_v("top_ativa", 0);       check_v(ativa);
        expect_v("miss_acerto", 0);     check_v(acerto_cnt);
        expect_v("miss_n", 0);          check_v(n_acertos);
        // Press during cooldown is dropped; a later one fires
        pulse_fire();
        step(34);
        expect_v("cooldown_drop", 0);   check_v(ativa);
        expect_v("after_cooldown_fire", 1);
        pulse_fire();
        wait_ativa(1'b1, 30, ok);
        check_v(ok);
        restart();

        // Hit with explosion hold
        x_nave = 10'd100; y_nave = 10'd200;
        x_inimigo = 10'd110; y_inimigo = 10'd150; inimigo_vivo = 1'b1;
        expect_v("hit_spawn_y", 199);
        pulse_fire();
        wait_ativa(1'b1, 30, ok);
        check_v(y);
        expect_v("hit_reach_179", 1);
        wait_y(10'd179, 100, ok);
        check_v(ok);
        a0 = acerto_cnt;
        expect_v("hit_seen", 1);
        wait_acerto(8, ok);
        check_v(ok);
        expect_v("hit_x", 122);         check_v(x);
        expect_v("hit_y", 179);         check_v(y);
        expect_v("hit_expl", 1);        check_v(explodindo);
        expect_v("hit_n", 1);           check_v(n_acertos);
        step(1);
        expect_v("acerto_width", 0);    check_v(acerto);
        ecnt = 1;
        while (explodindo === 1'b1 && ecnt < 40) begin ecnt++; step(1); end
        expect_v("expl_cycles", 12);    check_v(ecnt);
        expect_v("post_hit_x", 1000);   check_v(x);
        expect_v("post_hit_y", 1000);   check_v(y);
        step(2);
        expect_v("acerto_total", 1);    check_v(acerto_cnt - a0);
        restart();

        // Dead enemy: no hit all the way to the top
        inimigo_vivo = 1'b0;
        a0 = acerto_cnt;
        e0 = expl_cnt;
        pulse_fire();
        expect_v("dead_top", 1);
        wait_y(10'd1000, 40, ok);
        wait_ativa(1'b1, 30, ok);
        wait_y(10'd1000, 600, ok);
        check_v(ok);
        expect_v("dead_n", 0);          check_v(n_acertos);
        expect_v("dead_acerto", 0);     check_v(acerto_cnt - a0);
        expect_v("dead_expl", 0);       check_v(expl_cnt - e0);
        restart();

        // Pause mid-flight
        inimigo_vivo = 1'b1;
        x_inimigo = 10'd300; y_inimigo = 10'd50;
        x_nave = 10'd100; y_nave = 10'd400;
        pulse_fire();
        expect_v("pause_reach", 1);
        wait_y(10'd391, 60, ok);
        check_v(ok);
        step(1);
        pausa = 1'b1;
        fx = x; fy = y;
        expect_v("pause_x", fx);
        expect_v("pause_y", fy);
        expect_v("pause_ativa", 1);
        step(20);
        pulse_fire();
        step(24);
        check_v(x); check_v(y); check_v(ativa);
        pausa = 1'b0;
        expect_v("resume_hold", 391);
        expect_v("resume_step", 389);
        step(2);
        check_v(y);
        step(1);
        check_v(y);
        restart();

        // Saturating hit counter
        x_nave = 10'd100; y_nave = 10'd160;
        x_inimigo = 10'd110; y_inimigo = 10'd150;
        timeouts = 0;
        for (int i = 0; i < 256; i++) begin
            pulse_fire();
            wait_acerto(80, ok);
            if (!ok) timeouts++;
            if (i == 99) begin
                expect_v("n_100", 100);  check_v(n_acertos);
            end
            if (i >= 254) begin
                expect_v("n_sat", 255);  check_v(n_acertos);
                expect_v("sat_pulse", 1); check_v(ok);
            end
            wait_y(10'd1000, 40, ok);
            if (!ok) timeouts++;
            step(24);
        end
        expect_v("sat_timeouts", 0);    check_v(timeouts);

        // Restart mid-flight clears everything on the next edge
        y_nave = 10'd400;
        pulse_fire();
        expect_v("rst_flying", 1);
        wait_ativa(1'b1, 30, ok);
        check_v(ok);
        step(5);
        reiniciarJogo = 1'b1;
        step(1);
        expect_v("rst_x", 1000);        check_v(x);
        expect_v("rst_y", 1000);        check_v(y);
        expect_v("rst_ativa", 0);       check_v(ativa);
        expect_v("rst_expl", 0);        check_v(explodindo);
        expect_v("rst_acerto", 0);      check_v(acerto);
        expect_v("rst_n", 0);           check_v(n_acertos);
        reiniciarJogo = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
